// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: symbol width, comma filler and the
// transmitter state encoding (also used by the receiver's probes).
package serial_pkg;
    localparam int SYM_W = 8;
    localparam logic [SYM_W-1:0] COMMA = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;
endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-bit serializer: valid/ready byte input, MSB-first serial output,
// comma filler in idle slots and a forced comma preamble after reset.
module paralelo_serial_tx
    import serial_pkg::*;
#(
    parameter int MIN_COMMAS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             sym_start,
    output logic             tx_active,
    output logic [CNT_W-1:0] data_cnt
);
    localparam int BIT_W = $clog2(SYM_W);
    localparam int CC_W  = $clog2(MIN_COMMAS + 1);

    // Handshake: a byte moves when in_valid && in_ready on a rising clk_32f;
    // in_ready comes from registers only, in_data/in_valid are ignored otherwise.
    tx_state_e        state_q, state_d;
    logic [SYM_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;

    logic transfer;
    logic sym_end;
    logic load_data;

    assign in_ready  = (state_q == RUN) && !hold_full_q;
    assign data_out  = shift_q[SYM_W-1];
    assign sym_start = (bit_cnt_q == '0);
    assign tx_active = (state_q == RUN);
    assign data_cnt  = data_cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        comma_cnt_d = comma_cnt_q;
        data_cnt_d  = data_cnt_q;
        load_data   = 1'b0;
        transfer    = in_valid && in_ready;
        sym_end     = (bit_cnt_q == BIT_W'(SYM_W - 1));
        bit_cnt_d   = bit_cnt_q + BIT_W'(1);

        if (!sym_end) begin
            shift_d = shift_q << 1;
            if (transfer) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                SYNC: begin
                    shift_d     = COMMA;
                    comma_cnt_d = comma_cnt_q + CC_W'(1);
                    if (comma_cnt_q == CC_W'(MIN_COMMAS - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // A held byte always wins; in_ready is low then, so no bypass can collide.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        load_data   = 1'b1;
                    end else if (transfer) begin
                        shift_d   = in_data;
                        load_data = 1'b1;
                    end else begin
                        shift_d = COMMA;
                    end
                end
                default: shift_d = COMMA;
            endcase
        end

        if (load_data && (data_cnt_q != {CNT_W{1'b1}})) begin
            data_cnt_d = data_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_q     <= SYNC;
            shift_q     <= COMMA;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            comma_cnt_q <= '0;
            data_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            comma_cnt_q <= comma_cnt_d;
            data_cnt_q  <= data_cnt_d;
        end
    end
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: slot-level stream model checked every cycle,
// plus directed scenarios with literal expectations and a symbol deframer.
module tb_paralelo_serial_tx;
    localparam int MC    = 4;
    localparam int CNT_W = 16;

    logic             clk_32f = 1'b0;
    logic             reset_L = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             data_out;
    logic             sym_start;
    logic             tx_active;
    logic [CNT_W-1:0] data_cnt;

    paralelo_serial_tx #(.MIN_COMMAS(MC), .CNT_W(CNT_W)) dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .sym_start(sym_start),
        .tx_active(tx_active),
        .data_cnt (data_cnt)
    );

    // clock / reset
    always #5 clk_32f = ~clk_32f;

    int n_vec = 0;
    int n_err = 0;

    // model state: cycle index since reset release, bytes waiting for a slot
    int         t = 0;
    bit         started = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_sym = 8'hBC;
    int         sent = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_syms[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // scoreboard: slot k (cycles 8k..8k+7) carries a comma while k <= MC,
    // afterwards the oldest byte accepted before cycle 8k, else a comma
    always @(negedge clk_32f) begin
        if (!reset_L) begin
            t = 0;
            started = 1'b1;
            exp_q.delete();
            rx_syms.delete();
            sent = 0;
        end else if (started) begin
            logic exp_ready;
            logic exp_active;
            if (t % 8 == 0) begin
                if (t >= 8 * (MC + 1) && exp_q.size() > 0) begin
                    cur_sym = exp_q.pop_front();
                    sent++;
                end else begin
                    cur_sym = 8'hBC;
                end
            end
            exp_active = (t >= 8 * MC);
            exp_ready  = exp_active && (exp_q.size() == 0);
            n_vec++;
            if (data_out !== cur_sym[7 - (t % 8)] || sym_start !== (t % 8 == 0) ||
                in_ready !== exp_ready || tx_active !== exp_active ||
                data_cnt !== CNT_W'(sent)) begin
                n_err++;
                $display("FAIL cycle_model t=%0d: got out=%b start=%b rdy=%b act=%b cnt=%0d expected out=%b start=%b rdy=%b act=%b cnt=%0d",
                         t, data_out, sym_start, in_ready, tx_active, data_cnt,
                         cur_sym[7 - (t % 8)], (t % 8 == 0), exp_ready, exp_active, sent);
            end
            if (in_valid && exp_ready) exp_q.push_back(in_data);
            rx_sh = {rx_sh[6:0], data_out};
            if (t % 8 == 7) rx_syms.push_back(rx_sh);
            t++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_L  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
        reset_L = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (t != n && g < 500) begin
            step();
            g++;
        end
        if (t != n) chk($sformatf("wait_cyc_%0d", n), t, n);
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        acc      = -1;
        in_valid = 1'b1;
        in_data  = b;
        for (int g = 0; g < 40 && acc < 0; g++) begin
            if (in_ready) acc = t;
            step();
        end
        if (acc < 0) chk($sformatf("send_%0h_timeout", b), 0, 1);
    endtask

    task automatic chk_sym(input int idx, input logic [7:0] exp);
        chk($sformatf("sym%0d", idx), (idx < rx_syms.size()) ? {24'h0, rx_syms[idx]} : 32'hDEAD, {24'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // 1: idle after reset
        do_reset(3);
        chk("rst_data_out", data_out, 1);
        chk("rst_sym_start", sym_start, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_data_cnt", data_cnt, 0);
        wait_cyc(31);
        chk("ready_c31", in_ready, 0);
        chk("active_c31", tx_active, 0);
        step();
        chk("ready_c32", in_ready, 1);
        chk("active_c32", tx_active, 1);
        wait_cyc(64);
        for (int i = 0; i < 8; i++) chk_sym(i, 8'hBC);

        // 2: FF at cycle 32, EE right behind it
        do_reset(2);
        wait_cyc(32);
        send(8'hFF, acc);
        chk("acc_ff", acc, 32);
        send(8'hEE, acc);
        chk("acc_ee", acc, 40);
        in_valid = 1'b0;
        wait_cyc(72);
        for (int i = 0; i < 5; i++) chk_sym(i, 8'hBC);
        chk_sym(5, 8'hFF);
        chk_sym(6, 8'hEE);
        chk_sym(7, 8'hBC);
        chk("cnt_t2", data_cnt, 2);

        // 3: bypass on the last bit of a symbol
        wait_cyc(79);
        send(8'hA5, acc);
        in_valid = 1'b0;
        chk("acc_a5", acc, 79);
        chk("ready_after_bypass", in_ready, 1);
        chk("msb_a5", data_out, 1);

        // 4: hold occupied, next byte waits for the drain
        wait_cyc(90);
        send(8'h5A, acc);
        chk("acc_5a", acc, 90);
        chk("ready_hold_full", in_ready, 0);
        send(8'h33, acc);
        in_valid = 1'b0;
        chk("acc_33", acc, 96);
        wait_cyc(112);
        chk_sym(10, 8'hA5);
        chk_sym(11, 8'hBC);
        chk_sym(12, 8'h5A);
        chk_sym(13, 8'h33);
        chk("cnt_t4", data_cnt, 5);

        // 5: reset in the middle of a data byte
        wait_cyc(120);
        send(8'hC3, acc);
        in_valid = 1'b0;
        wait_cyc(131);
        chk("cnt_before_abort", data_cnt, 6);
        do_reset(1);
        chk("abort_data_out", data_out, 1);
        chk("abort_sym_start", sym_start, 1);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_tx_active", tx_active, 0);
        chk("abort_data_cnt", data_cnt, 0);
        wait_cyc(32);
        chk("abort_ready_c32", in_ready, 1);
        wait_cyc(48);
        for (int i = 0; i < 6; i++) chk_sym(i, 8'hBC);
        chk("cnt_after_abort", data_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
